// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: requester ownership encoding and SRAM-like access sizes.
package cpu_bus_pkg;

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

endpackage

// File: rtl/owner_fifo.sv
// Owner FIFO: remembers which requester owns each accepted-but-unanswered request.
module owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign push_en = push & ~full;
  assign pop_en  = pop & ~empty;

  // Storage is never reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= din;
  end

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Two-master SRAM-like bus arbiter (fetch vs load/store) with in-order response routing.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority with data side winning.
module sram_arbiter
  import cpu_bus_pkg::*;
#(
  parameter int OUTST_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  owner_e grant;
  owner_e lock_owner_q;
  logic   lock_q;
  logic   lock_hold;
  logic   gnt_req;
  logic   gnt_data;
  logic   hs;
  logic   pop;
  logic   fifo_full;
  logic   fifo_empty;
  logic   fifo_head;

`ifdef ARB_RR_EN
  owner_e last_grant_q;
`endif

  // A stalled request keeps its grant only while its owner still asserts req.
  assign lock_hold = lock_q & ((lock_owner_q == OWNER_DATA) ? data_req : inst_req);

  always_comb begin
    grant = OWNER_INST;
    if (lock_hold) begin
      grant = lock_owner_q;
    end else if (inst_req && data_req) begin
`ifdef ARB_RR_EN
      grant = (last_grant_q == OWNER_INST) ? OWNER_DATA : OWNER_INST;
`else
      grant = OWNER_DATA;
`endif
    end else if (data_req) begin
      grant = OWNER_DATA;
    end
  end

  assign gnt_data  = (grant == OWNER_DATA);
  assign gnt_req   = gnt_data ? data_req : inst_req;
  assign mem_req   = resetn & gnt_req & ~fifo_full;
  assign mem_wr    = gnt_data ? data_wr    : inst_wr;
  assign mem_size  = gnt_data ? data_size  : inst_size;
  assign mem_addr  = gnt_data ? data_addr  : inst_addr;
  assign mem_wstrb = gnt_data ? data_wstrb : inst_wstrb;
  assign mem_wdata = gnt_data ? data_wdata : inst_wdata;

  assign hs           = mem_req & mem_addr_ok;
  assign inst_addr_ok = hs & ~gnt_data;
  assign data_addr_ok = hs &  gnt_data;

  // Responses with no outstanding owner are dropped silently.
  assign pop          = resetn & mem_data_ok & ~fifo_empty;
  assign inst_data_ok = pop & (fifo_head == OWNER_INST);
  assign data_data_ok = pop & (fifo_head == OWNER_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_INST;
    end else begin
      lock_q <= mem_req & ~mem_addr_ok;
      if (mem_req && !mem_addr_ok) lock_owner_q <= grant;
    end
  end

`ifdef ARB_RR_EN
  always_ff @(posedge clk) begin
    if (!resetn)  last_grant_q <= OWNER_INST;
    else if (hs)  last_grant_q <= grant;
  end
`endif

  owner_fifo #(
    .DEPTH (OUTST_DEPTH)
  ) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (hs),
    .din    (grant),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: inputs change on the falling edge, outputs checked 1 time unit later.
module tb_sram_arbiter;
  import cpu_bus_pkg::*;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata;
  logic [3:0]  inst_wstrb;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int vectors = 0;
  int errs    = 0;

  sram_arbiter #(.OUTST_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and apply one vector.
  task automatic drive(input logic rn, input logic ireq, input logic dreq,
                       input logic aok, input logic dok, input logic [31:0] rdata);
    @(negedge clk);
    resetn      = rn;
    inst_req    = ireq;
    data_req    = dreq;
    mem_addr_ok = aok;
    mem_data_ok = dok;
    mem_rdata   = rdata;
    #1;
  endtask

  initial begin
    resetn = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    inst_wr = 1'b0; inst_size = SZ_W; inst_addr = 32'h0000_2000; inst_wstrb = 4'h0; inst_wdata = 32'h0;
    data_wr = 1'b0; data_size = SZ_W; data_addr = 32'h0000_1000; data_wstrb = 4'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // Reset held while requests and responses are active: everything quiet.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Single data-side load.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("ld_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    chk("ld_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    chk("ld_mem_addr", mem_addr, 32'h0000_1000);
    chk("ld_mem_size", {30'd0, mem_size}, {30'd0, SZ_W});
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("ld_idle_mem_req", {31'd0, mem_req}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("ld_data_data_ok", {31'd0, data_data_ok}, 32'd1);
    chk("ld_data_rdata", data_rdata, 32'hDEAD_BEEF);
    chk("ld_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678);
    chk("ld_extra_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);

    // Both requesting every cycle after a fresh reset.
    data_addr = 32'h0000_3000;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
      chk($sformatf("arb_addr_%0d", i), mem_addr,
          (RR && (i % 2 == 1)) ? 32'h0000_2000 : 32'h0000_3000);
      chk($sformatf("arb_ok_%0d", i), {30'd0, inst_addr_ok, data_addr_ok},
          (RR && (i % 2 == 1)) ? 32'd2 : 32'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("full_mem_req", {31'd0, mem_req}, 32'd0);
    chk("full_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0001);
    chk("full_pop_mem_req", {31'd0, mem_req}, 32'd0);
    chk("full_pop_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'hA5A5_0002);
    chk("pushpop_mem_req", {31'd0, mem_req}, 32'd1);
    chk("pushpop_data_ok", {30'd0, inst_data_ok, data_data_ok}, RR ? 32'd2 : 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("refill_mem_req", {31'd0, mem_req}, 32'd1);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("refull_mem_req", {31'd0, mem_req}, 32'd0);

    // Stalled fetch keeps the grant even when the data side joins in.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("lock_c0_addr", mem_addr, 32'h0000_2000);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("lock_c1_addr", mem_addr, 32'h0000_2000);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("lock_c2_addr", mem_addr, 32'h0000_2000);
    chk("lock_c2_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("lock_c3_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("lock_c4_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);

    // Data side stalls then withdraws; fetch takes over immediately.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wd_stall_req", {31'd0, mem_req}, 32'd1);
    chk("wd_stall_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wd_inst_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    chk("wd_inst_addr", mem_addr, 32'h0000_2000);

    // Outstanding order is I, D, I; responses must follow it.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1111_1111);
    chk("ord0_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    chk("ord0_rdata", inst_rdata, 32'h1111_1111);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h2222_2222);
    chk("ord1_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd1);
    chk("ord1_rdata", data_rdata, 32'h2222_2222);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h3333_3333);
    chk("ord2_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd2);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h4444_4444);
    chk("ord_extra_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);

    // Reset with two outstanding discards them.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst2_acc0", {31'd0, data_addr_ok}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst2_acc1", {31'd0, data_addr_ok}, 32'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h5555_5555);
    chk("rst2_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst2_during_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h6666_6666);
    chk("rst2_after_ok0", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h7777_7777);
    chk("rst2_after_ok1", {30'd0, inst_data_ok, data_data_ok}, 32'd0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
